spi_ram: RTL and testbench

SPI_RAM -- requirements
Module: spi_ram

---
 rtl/spi_ram_pkg.sv | 15 +
 rtl/spi_ram_if.sv | 11 +
 rtl/spi_ram_mem.sv | 21 ++
 rtl/spi_ram.sv | 60 ++++++
 tb/tb_spi_ram.sv | 120 ++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared opcodes, default sizes and a command-word builder for spi_ram, its SPI slave and benches
package spi_ram_pkg;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int CMD_W = 10;
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;
  function automatic logic [CMD_W-1:0] cmd(input opcode_e op, input logic [7:0] payload);
    return {op, payload};
  endfunction
endpackage

// File: rtl/spi_ram_if.sv
// spi_ram_if: SPI-slave <-> RAM link; din/rx_valid toward the RAM, dout/tx_valid/err back (master = SPI slave, slave = RAM)
interface spi_ram_if;
  import spi_ram_pkg::*;
  logic [CMD_W-1:0] din;
  logic rx_valid;
  logic [7:0] dout;
  logic tx_valid;
  logic err;
  modport master(output din, rx_valid, input dout, tx_valid, err);
  modport slave(input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: byte storage, one sync write port (we/wr_addr/wr_data) and one sync read port (re/rd_addr -> rd_data)
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [7:0]           rd_data
);
  logic [7:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/spi_ram.sv
// spi_ram: command decoder in front of spi_ram_mem; clk, rst (sync, active-high), bus = spi_ram_if.slave (din/rx_valid in, dout/tx_valid/err out)
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int AUTO_INC  = 0
) (
  input logic      clk,
  input logic      rst,
  spi_ram_if.slave bus
);
  opcode_e op;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic wr_addr_ok, rd_addr_ok, we, re, tx_valid, err;
  logic [7:0] rd_data;
  assign op = opcode_e'(bus.din[9:8]);
  assign we = bus.rx_valid && !rst && op == WR_DATA && wr_addr_ok;
  assign re = bus.rx_valid && !rst && op == RD_DATA && rd_addr_ok;
  // rd_data only moves on a valid read, so masking with tx_valid gives hold-until-next-command and clear-on-other-command
  assign bus.dout = tx_valid ? rd_data : 8'h00;
  assign bus.tx_valid = tx_valid;
  assign bus.err = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
      tx_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= bus.rx_valid && ((op == WR_DATA && !wr_addr_ok) || (op == RD_DATA && !rd_addr_ok));
      if (bus.rx_valid) begin
        tx_valid <= re;
        if (op == WR_ADDR) begin
          wr_addr <= bus.din[ADDR_SIZE-1:0];
          wr_addr_ok <= 1'b1;
        end else if (we && AUTO_INC != 0) begin
          wr_addr <= wr_addr + ADDR_SIZE'(1);
        end
        if (op == RD_ADDR) begin
          rd_addr <= bus.din[ADDR_SIZE-1:0];
          rd_addr_ok <= 1'b1;
        end else if (re && AUTO_INC != 0) begin
          rd_addr <= rd_addr + ADDR_SIZE'(1);
        end
      end
    end
  end
  spi_ram_mem #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk(clk),
    .we(we),
    .wr_addr(wr_addr),
    .wr_data(bus.din[7:0]),
    .re(re),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed-vector bench for spi_ram with AUTO_INC=0 (u0) and AUTO_INC=1 (u1)
module tb_spi_ram;
  import spi_ram_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  spi_ram_if if0();
  spi_ram_if if1();
  spi_ram #(.AUTO_INC(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  spi_ram #(.AUTO_INC(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", tag, got, exp);
    end
  endtask
  task automatic outs0(input string tag, input logic [7:0] d, input logic t, input logic e);
    check({tag, " dout"}, if0.dout, d);
    check({tag, " tx_valid"}, {7'b0, if0.tx_valid}, {7'b0, t});
    check({tag, " err"}, {7'b0, if0.err}, {7'b0, e});
  endtask
  task automatic send(input bit d1, input logic [9:0] c);
    if (d1) begin
      if1.din = c;
      if1.rx_valid = 1'b1;
    end else begin
      if0.din = c;
      if0.rx_valid = 1'b1;
    end
    @(negedge clk);
    if0.rx_valid = 1'b0;
    if1.rx_valid = 1'b0;
  endtask
  initial begin
    if0.din = '0;
    if0.rx_valid = 1'b0;
    if1.din = '0;
    if1.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    outs0("reset u0", 8'h00, 1'b0, 1'b0);
    check("reset u1 tx_valid", {7'b0, if1.tx_valid}, 8'h00);
    check("reset u1 err", {7'b0, if1.err}, 8'h00);
    send(0, cmd(WR_DATA, 8'h55));
    outs0("wdata no addr", 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("err one cycle", {7'b0, if0.err}, 8'h00);
    send(0, cmd(RD_DATA, 8'h00));
    outs0("rdata no addr", 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("err one cycle rd", {7'b0, if0.err}, 8'h00);
    send(0, cmd(WR_ADDR, 8'h3C));
    send(0, cmd(WR_DATA, 8'hA5));
    send(0, cmd(RD_ADDR, 8'h3C));
    outs0("rd_addr", 8'h00, 1'b0, 1'b0);
    send(0, cmd(RD_DATA, 8'hC3));
    outs0("basic read", 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if0.din = 10'(i * 97 + 300);
      @(negedge clk);
      check("hold dout", if0.dout, 8'hA5);
      check("hold tx_valid", {7'b0, if0.tx_valid}, 8'h01);
    end
    send(0, cmd(WR_ADDR, 8'h00));
    outs0("clear on cmd", 8'h00, 1'b0, 1'b0);
    send(0, cmd(WR_ADDR, 8'h10));
    send(0, cmd(WR_DATA, 8'h9C));
    send(0, cmd(RD_ADDR, 8'h10));
    send(0, cmd(RD_DATA, 8'h00));
    outs0("b2b read", 8'h9C, 1'b1, 1'b0);
    send(0, cmd(WR_DATA, 8'h5A));
    outs0("wr clears tx", 8'h00, 1'b0, 1'b0);
    send(0, cmd(RD_DATA, 8'h00));
    outs0("rd after wr", 8'h5A, 1'b1, 1'b0);
    send(0, cmd(RD_DATA, 8'h00));
    outs0("fixed addr reread", 8'h5A, 1'b1, 1'b0);
    send(0, cmd(WR_ADDR, 8'h00));
    send(0, cmd(WR_DATA, 8'hEE));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(0, cmd(WR_DATA, 8'h55));
    outs0("wdata after rst", 8'h00, 1'b0, 1'b1);
    send(0, cmd(RD_ADDR, 8'h00));
    send(0, cmd(RD_DATA, 8'h00));
    outs0("mem kept", 8'hEE, 1'b1, 1'b0);
    send(0, cmd(WR_ADDR, 8'h20));
    send(0, cmd(WR_DATA, 8'h44));
    send(0, cmd(RD_ADDR, 8'h20));
    send(0, cmd(RD_DATA, 8'h00));
    outs0("pre rst read", 8'h44, 1'b1, 1'b0);
    rst = 1'b1;
    send(0, cmd(WR_DATA, 8'h77));
    rst = 1'b0;
    outs0("rst beats cmd", 8'h00, 1'b0, 1'b0);
    send(0, cmd(WR_DATA, 8'h33));
    outs0("wr_addr_ok cleared", 8'h00, 1'b0, 1'b1);
    send(0, cmd(RD_DATA, 8'h00));
    outs0("rd_addr_ok cleared", 8'h00, 1'b0, 1'b1);
    send(0, cmd(RD_ADDR, 8'h20));
    send(0, cmd(RD_DATA, 8'h00));
    outs0("discarded write", 8'h44, 1'b1, 1'b0);
    send(1, cmd(WR_ADDR, 8'hFF));
    send(1, cmd(WR_DATA, 8'h11));
    send(1, cmd(WR_DATA, 8'h22));
    send(1, cmd(RD_ADDR, 8'hFF));
    send(1, cmd(RD_DATA, 8'h00));
    check("inc mem[ff]", if1.dout, 8'h11);
    check("inc tx_valid", {7'b0, if1.tx_valid}, 8'h01);
    send(1, cmd(RD_DATA, 8'h00));
    check("inc wrap mem[00]", if1.dout, 8'h22);
    check("inc reload tx_valid", {7'b0, if1.tx_valid}, 8'h01);
    check("inc err", {7'b0, if1.err}, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
